// File: rtl/led_rotate_sequencer_pkg.sv
// Shared types and default constants for the rotating-LED run/stop/step sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } seq_state_t;

  localparam int unsigned DEF_LED_W           = 3;
  localparam logic [2:0]  DEF_LED_INIT        = 3'b110;
  localparam int unsigned DEF_TICK_CYCLES     = 13_500_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 270_000;

endpackage

// File: rtl/led_rotate_sequencer_if.sv
// Board-facing bundle: raw active-low buttons in, LED pattern and status out.
interface led_rotate_sequencer_if #(
  parameter int unsigned LED_W = 3
);

  logic             button_0;
  logic             button_1;
  logic             button_2;
  logic [LED_W-1:0] led;
  logic             running;
  logic             dir;

  modport master (
    output button_0,
    output button_1,
    output button_2,
    input  led,
    input  running,
    input  dir
  );

  modport slave (
    input  button_0,
    input  button_1,
    input  button_2,
    output led,
    output running,
    output dir
  );

endinterface

// File: rtl/led_rotate_sequencer_debounce.sv
// One button channel: 2-flop synchronizer, stability counter and one-shot press pulse.
module button_debounce
  import led_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic             press_q;
  logic             press_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Stability counter: a level change is accepted only after an unbroken run of differing samples.
  always_comb begin
    level_d = level_q;
    cnt_d   = CNT_ZERO;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = CNT_ZERO;
      end else begin
        level_d = level_q;
        cnt_d   = cnt_q + CNT_ONE;
      end
    end else begin
      level_d = level_q;
      cnt_d   = CNT_ZERO;
    end
    press_d = level_q & ~level_d;
  end

  // Synchronizer, debounced level and press pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= CNT_ZERO;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/led_rotate_sequencer.sv
// Run/stop/step sequencer: debounced button commands drive an FSM that times and rotates the LED pattern.
module led_rotate_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned      LED_W           = DEF_LED_W,
  parameter logic [LED_W-1:0] LED_INIT        = DEF_LED_INIT,
  parameter int unsigned      TICK_CYCLES     = DEF_TICK_CYCLES,
  parameter int unsigned      DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  led_rotate_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(TICK_CYCLES);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [2:0]       btn_n_s;
  logic [2:0]       level_s;
  logic [2:0]       press_s;

  seq_state_t       state_q;
  seq_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             dir_q;
  logic             dir_d;
  logic [LED_W-1:0] led_q;
  logic [LED_W-1:0] led_d;
  logic             running_q;
  logic [LED_W-1:0] led_rot_s;

  assign btn_n_s = {bus.button_2, bus.button_1, bus.button_0};

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_btn
      button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_n_s[g]),
        .level (level_s[g]),
        .press (press_s[g])
      );
    end
  endgenerate

  // One-position rotation of the current pattern in the current direction.
  always_comb begin
    if (dir_q) begin
      led_rot_s = {led_q[0], led_q[LED_W-1:1]};
    end else begin
      led_rot_s = {led_q[LED_W-2:0], led_q[LED_W-1]};
    end
  end

  // Next-state logic; STOP wins over everything, and STEP ignores all presses.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    led_d   = led_q;
    case (state_q)
      ST_STOP: begin
        cnt_d = CNT_ZERO;
        if (press_s[0]) begin
          state_d = ST_STOP;
        end else if (press_s[1]) begin
          state_d = ST_RUN;
        end else if (press_s[2]) begin
          state_d = ST_STEP;
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_RUN: begin
        if (press_s[0]) begin
          state_d = ST_STOP;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_RUN;
          if (press_s[2]) begin
            dir_d = ~dir_q;
          end else begin
            dir_d = dir_q;
          end
          if (cnt_q == TICK_LAST) begin
            led_d = led_rot_s;
            cnt_d = CNT_ZERO;
          end else begin
            led_d = led_q;
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      ST_STEP: begin
        led_d   = led_rot_s;
        state_d = ST_STOP;
        cnt_d   = CNT_ZERO;
      end
      default: begin
        state_d = ST_STOP;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_STOP;
      cnt_q     <= CNT_ZERO;
      dir_q     <= 1'b0;
      led_q     <= LED_INIT;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      led_q     <= led_d;
      running_q <= (state_d == ST_RUN);
    end
  end

  assign bus.led     = led_q;
  assign bus.running = running_q;
  assign bus.dir     = dir_q;

endmodule

// File: tb/tb_led_rotate_sequencer.sv
// Randomized and directed bench for led_rotate_sequencer against a window/history reference model.
module tb_led_rotate_sequencer;

  localparam int LED_W = 3;
  localparam int TICK  = 4;
  localparam int DEB   = 3;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  led_rotate_sequencer_if #(.LED_W(LED_W)) bus ();

  led_rotate_sequencer #(
    .LED_W           (LED_W),
    .LED_INIT        (3'b110),
    .TICK_CYCLES     (TICK),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 0=STOP 1=RUN 2=STEP; buttons as 2-stage delay plus window of synced samples.
  int m_state, m_cnt, m_dir, m_led;
  int m_s1[3], m_s2[3], m_lvl[3], m_press[3];
  int m_win[3][DEB];

  function automatic int rot(input int v, input int d);
    if (d != 0) return (v / 2) + (v % 2) * 4;
    else        return ((v * 2) % 8) + (v / 4);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    int p[3];
    int raw[3];
    int all_diff;
    raw[0] = int'(bus.button_0);
    raw[1] = int'(bus.button_1);
    raw[2] = int'(bus.button_2);
    if (!rst_n) begin
      m_state = 0; m_cnt = 0; m_dir = 0; m_led = 6;
      for (int b = 0; b < 3; b++) begin
        m_s1[b] = 1; m_s2[b] = 1; m_lvl[b] = 1; m_press[b] = 0;
        for (int k = 0; k < DEB; k++) m_win[b][k] = 1;
      end
    end else begin
      for (int b = 0; b < 3; b++) p[b] = m_press[b];
      case (m_state)
        0: begin
          m_cnt = 0;
          if (p[0] != 0)      m_state = 0;
          else if (p[1] != 0) m_state = 1;
          else if (p[2] != 0) m_state = 2;
        end
        1: begin
          if (p[0] != 0) begin
            m_state = 0; m_cnt = 0;
          end else begin
            if (m_cnt == TICK - 1) begin
              m_led = rot(m_led, m_dir); m_cnt = 0;
            end else begin
              m_cnt++;
            end
            if (p[2] != 0) m_dir = 1 - m_dir;
          end
        end
        default: begin
          m_led = rot(m_led, m_dir); m_state = 0; m_cnt = 0;
        end
      endcase
      for (int b = 0; b < 3; b++) begin
        for (int k = DEB - 1; k > 0; k--) m_win[b][k] = m_win[b][k-1];
        m_win[b][0] = m_s2[b];
        all_diff = 1;
        for (int k = 0; k < DEB; k++) if (m_win[b][k] == m_lvl[b]) all_diff = 0;
        m_press[b] = 0;
        if (all_diff != 0) begin
          if (m_lvl[b] == 1) m_press[b] = 1;
          m_lvl[b] = 1 - m_lvl[b];
        end
        m_s2[b] = m_s1[b];
        m_s1[b] = raw[b];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("led", int'(bus.led), m_led);
    chk("running", int'(bus.running), (m_state == 1) ? 1 : 0);
    chk("dir", int'(bus.dir), m_dir);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_btn(input int b, input int hold, input int gap);
    if (b == 0) bus.button_0 = 1'b0;
    else if (b == 1) bus.button_1 = 1'b0;
    else bus.button_2 = 1'b0;
    ticks(hold);
    bus.button_0 = 1'b1; bus.button_1 = 1'b1; bus.button_2 = 1'b1;
    ticks(gap);
  endtask

  initial begin
    int led_before;
    int dir_before;
    int seg;
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    bus.button_0 = 1'b1; bus.button_1 = 1'b1; bus.button_2 = 1'b1;
    ticks(3);
    rst_n = 1'b1;

    // 1: idle after reset
    ticks(50);
    chk("t1_led", int'(bus.led), 6);
    chk("t1_running", int'(bus.running), 0);
    chk("t1_dir", int'(bus.dir), 0);

    // 2: start, latency 6 edges, rotation every 4
    bus.button_1 = 1'b0;
    ticks(5);
    chk("t2_run_early", int'(bus.running), 0);
    tick();
    chk("t2_run", int'(bus.running), 1);
    chk("t2_led0", int'(bus.led), 6);
    ticks(3);
    chk("t2_led_hold", int'(bus.led), 6);
    tick();
    chk("t2_led1", int'(bus.led), 5);
    bus.button_1 = 1'b1;
    ticks(4);
    chk("t2_led2", int'(bus.led), 3);
    ticks(4);
    chk("t2_led3", int'(bus.led), 6);

    // 3: stop, then bounce start before a clean hold
    press_btn(0, 8, 8);
    chk("t3_stopped", int'(bus.running), 0);
    bus.button_1 = 1'b0; tick();
    bus.button_1 = 1'b1; tick();
    bus.button_1 = 1'b0; tick();
    bus.button_1 = 1'b1; tick();
    chk("t3_bounce_norun", int'(bus.running), 0);
    bus.button_1 = 1'b0;
    ticks(5);
    chk("t3_run_early", int'(bus.running), 0);
    tick();
    chk("t3_run", int'(bus.running), 1);
    ticks(4);
    bus.button_1 = 1'b1;
    ticks(8);

    // 4: reverse direction while running
    press_btn(2, 6, 0);
    chk("t4_dir", int'(bus.dir), 1);
    ticks(20);

    // 5: two single steps while stopped
    press_btn(0, 8, 8);
    led_before = m_led;
    dir_before = m_dir;
    press_btn(2, 6, 6);
    press_btn(2, 6, 6);
    chk("t5_led", int'(bus.led), rot(rot(led_before, dir_before), dir_before));
    chk("t5_running", int'(bus.running), 0);

    // 6a: stop and start together in STOP
    bus.button_0 = 1'b0; bus.button_1 = 1'b0;
    ticks(8);
    bus.button_0 = 1'b1; bus.button_1 = 1'b1;
    ticks(8);
    chk("t6_both_stop", int'(bus.running), 0);

    // 6b: reset while running
    press_btn(1, 7, 9);
    chk("t6_pre_run", int'(bus.running), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_rst_led", int'(bus.led), 6);
    chk("t6_rst_run", int'(bus.running), 0);
    chk("t6_rst_dir", int'(bus.dir), 0);
    ticks(10);

    // Randomized segments of button patterns with occasional reset
    for (seg = 0; seg < 600; seg++) begin
      bus.button_0 = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
      bus.button_1 = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      bus.button_2 = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      rst_n = ($urandom_range(0, 60) == 0) ? 1'b0 : 1'b1;
      ticks($urandom_range(1, 12));
      rst_n = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
